// File: rtl/sample_stream_arbiter_pkg.sv
// Shared types and default sizing for the sample-path arbiter and its
// neighbouring slot deserializers.
package sample_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int unsigned ARB_NUM_PORTS = 4;
    localparam int unsigned ARB_MAX_BURST = 8;
    localparam int unsigned ARB_SLOT_BITS = $clog2(ARB_NUM_PORTS);

    typedef logic [ARB_SLOT_BITS-1:0] slot_index_t;

endpackage

// File: rtl/sample_stream_arbiter_if.sv
// Per-slot request streams in, one tagged merged stream out.
interface sample_stream_arbiter_if
    import sample_arb_pkg::*;
#(
    parameter int unsigned num_ports = ARB_NUM_PORTS,
    parameter int unsigned num_bits  = 48
);
    localparam int unsigned SLOT_W = $clog2(num_ports);

    logic [num_ports-1:0]          in_valid;
    logic [num_ports-1:0]          in_ready;
    logic [num_ports*num_bits-1:0] in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [num_bits-1:0]           out_data;
    logic [SLOT_W-1:0]             out_slot;
    logic                          out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_slot, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_slot, out_last
    );

endinterface

// File: rtl/sample_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after i_last_grant,
// wrapping modulo num_ports.
module rr_pick #(
    parameter  int unsigned num_ports = 4,
    localparam int unsigned SLOT_W    = $clog2(num_ports)
) (
    input  logic [num_ports-1:0] i_req,
    input  logic [SLOT_W-1:0]    i_last_grant,
    output logic                 o_any,
    output logic [SLOT_W-1:0]    o_index
);

    logic        w_found;
    int unsigned w_idx;

    always_comb begin
        o_any   = |i_req;
        o_index = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int unsigned k = 1; k <= num_ports; k++) begin
            w_idx = (32'(i_last_grant) + k) % num_ports;
            if (!w_found && i_req[w_idx[SLOT_W-1:0]]) begin
                o_index = w_idx[SLOT_W-1:0];
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sample_stream_arbiter.sv
// Round-robin burst arbiter merging per-slot sample streams into the shared
// host sample path; a granted slot keeps the path until its burst is done.
module sample_stream_arbiter
    import sample_arb_pkg::*;
#(
    parameter  int unsigned num_ports = ARB_NUM_PORTS,
    parameter  int unsigned num_bits  = 48,
    parameter  int unsigned max_burst = ARB_MAX_BURST,
    localparam int unsigned bl_bits   = $clog2(max_burst + 1),
    localparam int unsigned SLOT_W    = $clog2(num_ports)
) (
    input  logic                         sample_clk,
    input  logic                         reset_n,
    input  logic                         i_enable,
    input  logic [num_ports*bl_bits-1:0] i_burst_len,
    output logic                         o_busy,
    sample_stream_arbiter_if.slave       bus
);

    arb_state_t          r_state,      w_state_nxt;
    logic [SLOT_W-1:0]   r_grant,      w_grant_nxt;
    logic [SLOT_W-1:0]   r_last_grant, w_last_nxt;
    logic [bl_bits-1:0]  r_len,        w_len_nxt;
    logic [bl_bits-1:0]  r_count,      w_count_nxt;

    logic                w_any;
    logic [SLOT_W-1:0]   w_pick;
    logic [bl_bits-1:0]  w_bl_raw;
    logic [bl_bits-1:0]  w_bl_clamped;
    logic                w_out_valid;
    logic                w_out_last;
    logic [num_bits-1:0] w_out_data;
    logic [num_ports-1:0] w_in_ready;

    rr_pick #(.num_ports(num_ports)) u_rr_pick (
        .i_req        (bus.in_valid),
        .i_last_grant (r_last_grant),
        .o_any        (w_any),
        .o_index      (w_pick)
    );

    // Length of the candidate's burst, forced into 1..max_burst.
    always_comb begin
        w_bl_raw = i_burst_len[int'(w_pick)*bl_bits +: bl_bits];
        if (w_bl_raw == '0)
            w_bl_clamped = bl_bits'(1);
        else if (w_bl_raw > bl_bits'(max_burst))
            w_bl_clamped = bl_bits'(max_burst);
        else
            w_bl_clamped = w_bl_raw;
    end

    always_ff @(posedge sample_clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= SLOT_W'(num_ports - 1);
            r_len        <= bl_bits'(1);
            r_count      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
            r_len        <= w_len_nxt;
            r_count      <= w_count_nxt;
        end
    end

    // Grant in IDLE; in BURST the granted port is passed straight through.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last_grant;
        w_len_nxt   = r_len;
        w_count_nxt = r_count;
        w_out_valid = 1'b0;
        w_out_last  = 1'b0;
        w_out_data  = '0;
        w_in_ready  = '0;
        case (r_state)
            IDLE: begin
                if (i_enable && w_any) begin
                    w_grant_nxt = w_pick;
                    w_len_nxt   = w_bl_clamped;
                    w_count_nxt = '0;
                    w_state_nxt = BURST;
                end
            end
            BURST: begin
                w_out_valid         = bus.in_valid[r_grant];
                w_in_ready[r_grant] = bus.out_ready;
                w_out_data          = bus.in_data[int'(r_grant)*num_bits +: num_bits];
                w_out_last          = (r_count == r_len - bl_bits'(1));
                if (w_out_valid && bus.out_ready) begin
                    w_count_nxt = r_count + bl_bits'(1);
                    if (w_out_last) begin
                        w_last_nxt  = r_grant;
                        w_state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    assign bus.out_valid = w_out_valid;
    assign bus.out_last  = w_out_last;
    assign bus.out_data  = w_out_data;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_slot  = r_grant;
    assign o_busy        = (r_state == BURST);

endmodule

// File: tb/tb_sample_stream_arbiter.sv
// Randomized bench: per-port sources feed the arbiter, a burst-level model
// predicts slot/last/valid and a per-port scoreboard checks every word.
module tb_sample_stream_arbiter;
    import sample_arb_pkg::*;

    localparam int unsigned NP = 4;
    localparam int unsigned NB = 48;
    localparam int unsigned MB = 8;
    localparam int unsigned BL = $clog2(MB + 1);

    typedef logic [NB-1:0] word_t;

    logic            sample_clk = 1'b0;
    logic            reset_n;
    logic            enable;
    logic [NP*BL-1:0] burst_len;
    logic            busy;

    sample_stream_arbiter_if #(.num_ports(NP), .num_bits(NB)) bus ();

    sample_stream_arbiter #(.num_ports(NP), .num_bits(NB), .max_burst(MB)) dut (
        .sample_clk  (sample_clk),
        .reset_n     (reset_n),
        .i_enable    (enable),
        .i_burst_len (burst_len),
        .o_busy      (busy),
        .bus         (bus.slave)
    );

    always #5 sample_clk = ~sample_clk;

    word_t src_q [NP][$];
    word_t exp_q [NP][$];
    bit    fire  [NP];
    int    total = 0;
    int    bad   = 0;
    int    out_words = 0;
    int    seq = 0;

    // stimulus knobs
    bit [NP-1:0] feed_mask = '0;
    int feed_pct  = 100;
    int gap_pct   = 0;
    int stall_pct = 0;
    int en_pct    = 0;
    bit rand_bl   = 1'b0;

    // burst-level reference state
    bit m_init = 1'b0;
    bit m_busy;
    int m_port;
    int m_left;
    int m_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input int p);
        word_t w;
        w = {4'(p), 12'(seq), 32'($urandom)};
        seq++;
        src_q[p].push_back(w);
        exp_q[p].push_back(w);
    endtask

    task automatic set_bl(input int p, input int v);
        burst_len[p*BL +: BL] = BL'(v);
    endtask

    function automatic int clamp_len(input int v);
        if (v == 0) return 1;
        if (v > int'(MB)) return int'(MB);
        return v;
    endfunction

    // One cycle: retire accepted words, then drive fresh inputs.
    task automatic step();
        logic [NP-1:0]    v;
        logic [NP*NB-1:0] d;
        @(posedge sample_clk);
        #1;
        v = '0;
        d = '0;
        for (int i = 0; i < int'(NP); i++) begin
            if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (feed_mask[i] && src_q[i].size() < 3 && $urandom_range(99) < feed_pct)
                push_word(i);
            if (src_q[i].size() > 0) begin
                d[i*NB +: NB] = src_q[i][0];
                v[i] = ($urandom_range(99) >= gap_pct);
            end
        end
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ($urandom_range(99) >= stall_pct);
        enable        = ($urandom_range(99) < en_pct);
        if (rand_bl) burst_len = (NP*BL)'($urandom);
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    // Monitor: compare DUT against the model, then advance the model.
    initial begin
        logic [NP-1:0] er;
        word_t         w;
        bit            ev;
        forever begin
            @(negedge sample_clk);
            if (m_init) begin
                chk("busy", 64'(busy), 64'(m_busy));
                chk("out_slot", 64'(bus.out_slot), 64'(m_port));
                if (!m_busy) begin
                    chk("idle_valid", 64'(bus.out_valid), 64'd0);
                    chk("idle_last", 64'(bus.out_last), 64'd0);
                    chk("idle_data", 64'(bus.out_data), 64'd0);
                    chk("idle_ready", 64'(bus.in_ready), 64'd0);
                end else begin
                    ev = bus.in_valid[m_port];
                    er = '0;
                    er[m_port] = bus.out_ready;
                    chk("out_valid", 64'(bus.out_valid), 64'(ev));
                    chk("in_ready", 64'(bus.in_ready), 64'(er));
                    if (ev && bus.out_ready) begin
                        out_words++;
                        if (exp_q[m_port].size() == 0) begin
                            chk("word_expected", 64'd0, 64'd1);
                        end else begin
                            w = exp_q[m_port].pop_front();
                            chk("out_data", 64'(bus.out_data), 64'(w));
                        end
                        chk("out_last", 64'(bus.out_last), 64'(m_left == 1));
                    end
                end
            end
            for (int i = 0; i < int'(NP); i++)
                fire[i] = bus.in_valid[i] && bus.in_ready[i];
            if (!reset_n) begin
                m_init = 1'b1;
                m_busy = 1'b0;
                m_port = 0;
                m_last = NP - 1;
            end else if (m_init) begin
                if (!m_busy) begin
                    if (enable && (|bus.in_valid)) begin
                        for (int k = 1; k <= int'(NP); k++) begin
                            int p;
                            p = (m_last + k) % NP;
                            if (!m_busy && bus.in_valid[p]) begin
                                m_busy = 1'b1;
                                m_port = p;
                                m_left = clamp_len(int'(burst_len[p*BL +: BL]));
                            end
                        end
                    end
                end else if (bus.in_valid[m_port] && bus.out_ready) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_last = m_port;
                    end
                end
            end
        end
    end

    initial begin
        int base;
        reset_n       = 1'b0;
        enable        = 1'b0;
        burst_len     = '0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        run(3);
        reset_n = 1'b1;

        // port 0 alone, burst of 4 with 6 words queued
        for (int i = 0; i < int'(NP); i++) set_bl(i, 1);
        set_bl(0, 4);
        for (int i = 0; i < 6; i++) push_word(0);
        en_pct = 100;
        base = out_words;
        run(15);
        chk("p0_words", 64'(out_words - base), 64'd6);
        chk("p0_holds_grant", 64'(busy), 64'd1);

        // all ports flooding, single-word bursts
        for (int i = 0; i < int'(NP); i++) set_bl(i, 1);
        feed_mask = '1;
        run(40);
        feed_mask = '0;
        run(30);

        // long burst on port 1, zero (treated as one) on port 2
        set_bl(1, 8);
        set_bl(2, 0);
        for (int i = 0; i < 8; i++) push_word(1);
        for (int i = 0; i < 2; i++) push_word(2);
        base = out_words;
        run(40);
        chk("p12_words", 64'(out_words - base), 64'd10);

        // enable low with everyone valid, then re-enable
        for (int i = 0; i < int'(NP); i++) set_bl(i, 2);
        feed_mask = '1;
        en_pct = 0;
        run(12);
        en_pct = 100;
        run(40);

        // random gaps, stalls and burst lengths
        feed_pct  = 60;
        gap_pct   = 30;
        stall_pct = 30;
        rand_bl   = 1'b1;
        run(800);
        en_pct = 60;
        run(600);

        // random synchronous resets on top of random traffic
        for (int c = 0; c < 600; c++) begin
            reset_n = ($urandom_range(39) != 0);
            step();
        end
        reset_n = 1'b1;
        run(20);

        chk("activity", 64'(out_words > 300), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
